// File: rtl/mem_stage_cache_requester.sv
// ----------------------------------------------------------------------------
// mem_stage_cache_requester
//
// Initiator side of the cache controller's CPU-facing interface. Takes a
// single-cycle read/write request from the ARM MEM stage, holds it on the
// cache side until the cache reports ready, freezes the pipeline for the
// duration, and captures read data. A stuck request is aborted after
// TIMEOUT_CYCLES cycles in BUSY and latches a sticky error flag.
//
// Parameters:
//   BASE_ADDR       data-memory base subtracted from the CPU byte address
//   TIMEOUT_CYCLES  max cycles spent in BUSY before abort (legal 1..255)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_r_en_in/mem_w_en_in  MEM-stage read / write request
//   address_in               CPU byte address
//   write_data_in            store data
//   freeze_out               pipeline stall while a request is outstanding
//   read_data_out            last completed read data
//   error_out                sticky timeout flag (cleared only by rst)
//   cache_address_out        word address to the cache (held while BUSY)
//   cache_write_data_out     held store data
//   cache_r_en_out           read request to the cache
//   cache_w_en_out           write request to the cache
//   cache_read_data_in       cache read data
//   cache_ready_in           cache completion strobe (only honoured in BUSY)
// ----------------------------------------------------------------------------
module mem_stage_cache_requester #(
    parameter logic [31:0] BASE_ADDR      = 32'd1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    output logic        freeze_out,
    output logic [31:0] read_data_out,
    output logic        error_out,
    output logic [31:0] cache_address_out,
    output logic [31:0] cache_write_data_out,
    output logic        cache_r_en_out,
    output logic        cache_w_en_out,
    input  logic [31:0] cache_read_data_in,
    input  logic        cache_ready_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit so the comparison against the limit never aliases.
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [8:0]  cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        r_en_q;
    logic        w_en_q;
    logic        err_q;

    logic        req_any;
    logic [31:0] addr_diff;
    logic [31:0] addr_word;

    assign req_any   = mem_r_en_in | mem_w_en_in;
    // Byte address relative to the data-memory base, wrapping below it.
    assign addr_diff = address_in - BASE_ADDR;
    assign addr_word = {2'b00, addr_diff[31:2]};
    assign cnt_d     = {1'b0, cnt_q} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req_any) begin
                        addr_q  <= addr_word;
                        wdata_q <= write_data_in;
                        // Write wins when both enables are asserted.
                        w_en_q  <= mem_w_en_in;
                        r_en_q  <= ~mem_w_en_in;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_d[7:0];
                    // Ready is checked first so a completion on the timeout
                    // cycle is treated as a success.
                    if (cache_ready_in) begin
                        if (r_en_q) begin
                            rdata_q <= cache_read_data_in;
                        end
                        r_en_q  <= 1'b0;
                        w_en_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (cnt_d == TIMEOUT_LIM) begin
                        err_q   <= 1'b1;
                        r_en_q  <= 1'b0;
                        w_en_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests seen here belong to the instruction being
                    // released, so they are deliberately not sampled.
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational in IDLE so the requesting instruction stalls in the same
    // cycle it presents its request.
    assign freeze_out = (state_q == ST_BUSY) | ((state_q == ST_IDLE) & req_any);

    assign read_data_out        = rdata_q;
    assign error_out            = err_q;
    assign cache_address_out    = addr_q;
    assign cache_write_data_out = wdata_q;
    assign cache_r_en_out       = r_en_q;
    assign cache_w_en_out       = w_en_q;

endmodule

// File: tb/tb_mem_stage_cache_requester.sv
// ----------------------------------------------------------------------------
// Bench for mem_stage_cache_requester. Instance 0 uses the default timeout,
// instance 1 uses TIMEOUT_CYCLES=4. A table of directed transactions covers
// the hand-picked cases; a random phase on instance 1 is checked against a
// transaction-level model (latency = min(ready delay, timeout)).
// ----------------------------------------------------------------------------
module tb_mem_stage_cache_requester;

    localparam int T1 = 4;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  mem_r;
    logic [1:0]  mem_w;
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [1:0]  freeze;
    logic [31:0] rdata  [2];
    logic [1:0]  err;
    logic [31:0] caddr  [2];
    logic [31:0] cwdata [2];
    logic [1:0]  cr_en;
    logic [1:0]  cw_en;
    logic [31:0] crdata [2];
    logic [1:0]  cready;

    int n_vec = 0;
    int n_bad = 0;

    mem_stage_cache_requester dut0 (
        .clk(clk), .rst(rst[0]),
        .mem_r_en_in(mem_r[0]), .mem_w_en_in(mem_w[0]),
        .address_in(addr[0]), .write_data_in(wdata[0]),
        .freeze_out(freeze[0]), .read_data_out(rdata[0]), .error_out(err[0]),
        .cache_address_out(caddr[0]), .cache_write_data_out(cwdata[0]),
        .cache_r_en_out(cr_en[0]), .cache_w_en_out(cw_en[0]),
        .cache_read_data_in(crdata[0]), .cache_ready_in(cready[0])
    );

    mem_stage_cache_requester #(.TIMEOUT_CYCLES(T1)) dut1 (
        .clk(clk), .rst(rst[1]),
        .mem_r_en_in(mem_r[1]), .mem_w_en_in(mem_w[1]),
        .address_in(addr[1]), .write_data_in(wdata[1]),
        .freeze_out(freeze[1]), .read_data_out(rdata[1]), .error_out(err[1]),
        .cache_address_out(caddr[1]), .cache_write_data_out(cwdata[1]),
        .cache_r_en_out(cr_en[1]), .cache_w_en_out(cw_en[1]),
        .cache_read_data_in(crdata[1]), .cache_ready_in(cready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          u;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          k;        // ready on this BUSY cycle, 0 = never
        logic [31:0] rd_ret;
        logic [31:0] exp_addr;
        int          exp_busy;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one request through IDLE -> BUSY x exp_busy -> DONE -> IDLE and
    // checks the cache-side handshake and the post-transaction state.
    task automatic run_txn(input vec_t v);
        int u;
        logic [1:0] exp_en;
        u = v.u;
        exp_en = v.w ? 2'b01 : 2'b10;   // {r_en, w_en}
        @(negedge clk);
        mem_r[u] = v.r; mem_w[u] = v.w; addr[u] = v.a; wdata[u] = v.d;
        cready[u] = 1'b0;
        #1;
        chk("idle_freeze", 32'(freeze[u]), 32'd1);
        chk("idle_en", 32'({cr_en[u], cw_en[u]}), 32'd0);
        for (int j = 1; j <= v.exp_busy; j++) begin
            @(negedge clk);
            cready[u] = (j == v.k);
            crdata[u] = (j == v.k) ? v.rd_ret : $urandom;
            #1;
            chk("busy_en", 32'({cr_en[u], cw_en[u]}), 32'(exp_en));
            chk("busy_addr", caddr[u], v.exp_addr);
            chk("busy_wdata", cwdata[u], v.d);
            chk("busy_freeze", 32'(freeze[u]), 32'd1);
        end
        // DONE: requests still held, a stray ready and junk data must be ignored.
        @(negedge clk);
        cready[u] = 1'b1;
        crdata[u] = $urandom;
        #1;
        chk("done_en", 32'({cr_en[u], cw_en[u]}), 32'd0);
        chk("done_freeze", 32'(freeze[u]), 32'd0);
        @(negedge clk);
        mem_r[u] = 1'b0; mem_w[u] = 1'b0; cready[u] = 1'b0;
        #1;
        chk("post_en", 32'({cr_en[u], cw_en[u]}), 32'd0);
        chk("post_freeze", 32'(freeze[u]), 32'd0);
        chk("post_rdata", rdata[u], v.exp_rd);
        chk("post_error", 32'(err[u]), 32'(v.exp_err));
        $display("txn u=%0d r=%0d w=%0d a=%h k=%0d -> caddr=%h rdata=%h err=%0d",
                 u, v.r, v.w, v.a, v.k, caddr[u], rdata[u], err[u]);
    endtask

    vec_t vt [8];

    initial begin
        vec_t v;
        logic [31:0] m_rd;
        logic        m_err;
        logic [31:0] diff;
        bit          ok;

        rst = 2'b11;
        mem_r = '0; mem_w = '0; cready = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; crdata[i] = '0;
        end

        //         u  r     w     addr      wdata         k  rd_ret        exp_addr      busy exp_rd        err
        vt[0] = '{0, 1'b0, 1'b1, 32'd1024, 32'hF0F0F0F0, 6, 32'h0,        32'h0,        6, 32'h0,        1'b0};
        vt[1] = '{0, 1'b1, 1'b0, 32'd1028, 32'h0,        1, 32'hAAAAAAAA, 32'h1,        1, 32'hAAAAAAAA, 1'b0};
        vt[2] = '{0, 1'b0, 1'b1, 32'd1040, 32'h12345678, 2, 32'h0,        32'h4,        2, 32'hAAAAAAAA, 1'b0};
        vt[3] = '{0, 1'b1, 1'b1, 32'd1032, 32'h00005555, 3, 32'h0BAD0BAD, 32'h2,        3, 32'hAAAAAAAA, 1'b0};
        vt[4] = '{0, 1'b1, 1'b0, 32'd0,    32'h0,        2, 32'h13572468, 32'h3FFFFF00, 2, 32'h13572468, 1'b0};
        vt[5] = '{1, 1'b1, 1'b0, 32'd2048, 32'h0,        0, 32'h0,        32'h100,      4, 32'h0,        1'b1};
        vt[6] = '{1, 1'b1, 1'b0, 32'd2052, 32'h0,        4, 32'hCAFEF00D, 32'h101,      4, 32'hCAFEF00D, 1'b1};
        vt[7] = '{1, 1'b1, 1'b0, 32'd1100, 32'h0,        2, 32'h00000001, 32'h13,       2, 32'h00000001, 1'b1};

        // Reset state while rst is held.
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_en", 32'({cr_en[i], cw_en[i]}), 32'd0);
            chk("rst_freeze", 32'(freeze[i]), 32'd0);
            chk("rst_rdata", rdata[i], 32'd0);
            chk("rst_error", 32'(err[i]), 32'd0);
            chk("rst_caddr", caddr[i], 32'd0);
            chk("rst_cwdata", cwdata[i], 32'd0);
        end
        #9 rst = 2'b00;

        for (int i = 0; i < 8; i++) run_txn(vt[i]);

        // Asynchronous reset in the middle of BUSY on instance 1.
        @(negedge clk);
        mem_r[1] = 1'b1; addr[1] = 32'd1200; wdata[1] = 32'h77777777;
        @(negedge clk);
        #1 chk("arst_pre_busy", 32'(cr_en[1]), 32'd1);
        #1 mem_r[1] = 1'b0; rst[1] = 1'b1;
        #1;
        chk("arst_en", 32'({cr_en[1], cw_en[1]}), 32'd0);
        chk("arst_freeze", 32'(freeze[1]), 32'd0);
        chk("arst_rdata", rdata[1], 32'd0);
        chk("arst_error", 32'(err[1]), 32'd0);
        #1 rst[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("arst_idle_en", 32'({cr_en[1], cw_en[1]}), 32'd0);
        chk("arst_idle_freeze", 32'(freeze[1]), 32'd0);
        $display("reset mid-BUSY: en=%0d%0d freeze=%0d err=%0d", cr_en[1], cw_en[1], freeze[1], err[1]);

        // Random phase against the transaction-level model.
        m_rd = 32'h0;
        m_err = 1'b0;
        for (int n = 0; n < 60; n++) begin
            v.u = 1;
            v.r = 1'($urandom_range(0, 1));
            v.w = 1'($urandom_range(0, 1));
            if (!v.r && !v.w) v.r = 1'b1;
            v.a = ($urandom_range(0, 1) == 1) ? $urandom
                                              : 32'd1024 + ($urandom_range(0, 255) << 2);
            v.d = $urandom;
            v.k = $urandom_range(0, 6);
            v.rd_ret = $urandom;
            diff = v.a - 32'd1024;
            v.exp_addr = diff >> 2;
            ok = (v.k >= 1) && (v.k <= T1);
            v.exp_busy = ok ? v.k : T1;
            if (ok && v.r && !v.w) m_rd = v.rd_ret;
            if (!ok) m_err = 1'b1;
            v.exp_rd = m_rd;
            v.exp_err = m_err;
            run_txn(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_cache_requester.md
Name: mem_stage_cache_requester

Overview:
- Initiator side of the cache controller's CPU-facing interface (address bus, r_en/w_en, write data, ready, read data).
- Sits between the ARM pipeline MEM stage and cache_controller.
- Converts a single-cycle MEM-stage request into a held request on the cache side, freezes the pipeline until the cache signals ready, and captures read data.
- Translates the CPU byte address into a cache word address and provides a stuck-request timeout with a sticky error flag.

Parameters:
- BASE_ADDR, 1024: data-memory base subtracted from the CPU byte address.
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY before the request is aborted; legal range 1..255.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- mem_r_en_in  input  1  MEM-stage read request.
- mem_w_en_in  input  1  MEM-stage write request.
- address_in  input  32  CPU byte address.
- write_data_in  input  32  store data.
- freeze_out  output  1  stalls the pipeline while a request is outstanding.
- read_data_out  output  32  last completed read data.
- error_out  output  1  sticky timeout flag.
- cache_address_out  output  32  word address to the cache.
- cache_write_data_out  output  32  held store data.
- cache_r_en_out  output  1  read request to the cache.
- cache_w_en_out  output  1  write request to the cache.
- cache_read_data_in  input  32  cache read data.
- cache_ready_in  input  1  cache completion.

Behaviour:
Reset (asynchronous, any state):
- State goes to IDLE.
- All cache_* outputs are 0.
- read_data_out is 0, error_out is 0, the timeout counter is 0.

Address translation:
- cache_address_out = (address_in - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic with wrap on underflow.
- The value is captured at acceptance and held constant until the request leaves BUSY.

State IDLE:
- cache_r_en_out = 0 and cache_w_en_out = 0.
- freeze_out = mem_r_en_in | mem_w_en_in. This is combinational so the requesting instruction is frozen in the same cycle.
- On a clock edge with either enable high, the block latches the translated address, write_data_in and the request type, then moves to BUSY.
- If both enables are high, the write wins and no read is issued.

State BUSY:
- Exactly one of cache_r_en_out / cache_w_en_out is 1. Address, data and type are held constant.
- freeze_out = 1.
- The counter increments every cycle.
- If cache_ready_in = 1 on an edge:
  - For a read, read_data_out <= cache_read_data_in.
  - Enables drop to 0 and the state moves to DONE.
- Else if the counter reaches TIMEOUT_CYCLES:
  - error_out <= 1, enables drop to 0, the state moves to DONE.
  - read_data_out is unchanged.
- If ready and timeout occur in the same cycle, ready wins and error_out is not set.

State DONE (one cycle):
- Enables are 0, freeze_out = 0 so the pipeline advances past the memory instruction.
- The counter clears. The next state is IDLE unconditionally.
- Requests present during DONE are ignored. They belong to the instruction being released; the next instruction's request is sampled in IDLE.

Latency and hold rules:
- A request accepted at edge N has enables high from edge N onward and for at least one full cycle.
- With cache_ready_in high at edge N+k, freeze_out falls after edge N+k. Minimum freeze is 2 cycles for a hit that is ready on its first BUSY cycle.
- cache_ready_in is ignored outside BUSY.
- read_data_out holds its value until the next successful read; writes never modify it.
- error_out is cleared only by rst.

Test Plan:
1. Reset mid-BUSY with rst pulsed asynchronously between edges -> enables, freeze_out, read_data_out and error_out are 0 immediately; the next cycle is IDLE.
2. Write address_in=1024, write_data_in=F0F0F0F0, cache ready after 6 cycles:
   - cache_address_out=0 and cache_w_en_out=1 for exactly 6 cycles.
   - freeze_out falls in DONE.
   - read_data_out stays 0.
3. Read address_in=1028, cache returns AAAAAAAA with ready on the first BUSY cycle:
   - cache_address_out=1.
   - freeze_out is high for 2 cycles.
   - read_data_out=AAAAAAAA persists through a following write of 12345678.
4. mem_r_en_in and mem_w_en_in both high, address 1032 -> only cache_w_en_out=1, cache_address_out=2.
5. Read with cache_ready_in never asserted, TIMEOUT_CYCLES=4:
   - Enables drop after 4 BUSY cycles, error_out=1 and stays high.
   - read_data_out is unchanged.
   - A subsequent normal read completes.
6. address_in=0 (below BASE_ADDR) -> cache_address_out=3FFFFF00 (wrapped); the request is handled normally.
